// File: rtl/keypad_entry.sv
// Keypad press decoder and BCD time-entry register. Finished entries are
// offered to the countdown timer over a valid/ready handshake.
module keypad_entry #(
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    clear,
    input  logic [9:0]              keys,
    input  logic                    key_start,
    input  logic                    key_cancel,
    input  logic                    db_ok,
    input  logic                    entry_en,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [3:0]              digit_cnt,
    output logic                    key_pulse,
    output logic                    load_valid,
    input  logic                    load_ready,
    output logic [4*NUM_DIGITS-1:0] time_out
);
    localparam int W = 4 * NUM_DIGITS;

    typedef enum logic [1:0] {IDLE, DECODE, HOLD, OFFER} state_t;

    state_t         state, state_nx;
    logic [W-1:0]   digits_nx, time_out_nx;
    logic [3:0]     cnt_nx;
    logic           pulse_nx;
    logic [11:0]    lines;
    logic           any_key;
    logic [3:0]     n_high;
    logic [3:0]     digit_val;
    logic           single;

    assign lines   = {key_cancel, key_start, keys};
    assign any_key = |lines;
    assign single  = (n_high == 4'd1);

    always_comb begin
        n_high    = '0;
        digit_val = '0;
        for (int i = 0; i < 12; i++) n_high = n_high + 4'(lines[i]);
        for (int i = 0; i < 10; i++) if (keys[i]) digit_val = 4'(i);
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state     <= IDLE;
            digits    <= '0;
            digit_cnt <= '0;
            key_pulse <= 1'b0;
            time_out  <= '0;
        end else begin
            state     <= state_nx;
            digits    <= digits_nx;
            digit_cnt <= cnt_nx;
            key_pulse <= pulse_nx;
            time_out  <= time_out_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        digits_nx   = digits;
        cnt_nx      = digit_cnt;
        time_out_nx = time_out;
        pulse_nx    = 1'b0;
        case (state)
            IDLE: if (db_ok && any_key) state_nx = DECODE;
            DECODE: begin
                state_nx = HOLD;
                if (single) begin
                    if (key_cancel) begin
                        digits_nx = '0;
                        cnt_nx    = '0;
                        pulse_nx  = 1'b1;
                    end else if (key_start) begin
                        if (entry_en && digit_cnt != 4'd0) begin
                            time_out_nx = digits;
                            pulse_nx    = 1'b1;
                            state_nx    = OFFER;
                        end
                    end else if (entry_en && digit_cnt < 4'(NUM_DIGITS)) begin
                        digits_nx = {digits[W-5:0], digit_val};
                        cnt_nx    = digit_cnt + 4'd1;
                        pulse_nx  = 1'b1;
                    end
                end
            end
            HOLD: if (!any_key) state_nx = IDLE;
            OFFER: begin
                // A transfer beats a simultaneous cancel; HOLD absorbs the held cancel.
                if (load_ready) begin
                    digits_nx = '0;
                    cnt_nx    = '0;
                    state_nx  = HOLD;
                end else if (key_cancel && db_ok) begin
                    digits_nx = '0;
                    cnt_nx    = '0;
                    pulse_nx  = 1'b1;
                    state_nx  = HOLD;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Derived from the state register so an asynchronous clear drops it at once.
    assign load_valid = (state == OFFER);
endmodule

// File: tb/tb_keypad_entry.sv
// Self-checking bench for keypad_entry: directed steps plus random presses
// checked against a press-level reference model.
module tb_keypad_entry;
    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         clear;
    logic [9:0]   keys;
    logic         key_start, key_cancel, db_ok, entry_en, load_ready;
    logic [W-1:0] digits, time_out;
    logic [3:0]   digit_cnt;
    logic         key_pulse, load_valid;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] m_digits;
    logic [3:0]   m_cnt;

    keypad_entry #(.NUM_DIGITS(N)) dut (
        .clk(clk), .clear(clear), .keys(keys), .key_start(key_start),
        .key_cancel(key_cancel), .db_ok(db_ok), .entry_en(entry_en),
        .digits(digits), .digit_cnt(digit_cnt), .key_pulse(key_pulse),
        .load_valid(load_valid), .load_ready(load_ready), .time_out(time_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] dkey(input int d);
        logic [11:0] v;
        v = '0;
        v[d] = 1'b1;
        return v;
    endfunction

    function automatic logic [3:0] which_digit(input logic [11:0] ln);
        logic [3:0] d;
        d = '0;
        for (int i = 0; i < 10; i++) if (ln[i]) d = 4'(i);
        return d;
    endfunction

    // Non-offering press: lines = {cancel, start, keys[9:0]}
    task automatic press(input logic [11:0] ln, input int hold);
        logic [W-1:0] ed;
        logic [3:0]   ec;
        int ep, pc, pat;
        ed = m_digits; ec = m_cnt; ep = 0;
        if ($countones(ln) == 1) begin
            if (ln[11]) begin
                ed = '0; ec = '0; ep = 1;
            end else if (!ln[10] && entry_en && ec < 4'(N)) begin
                ed = {ed[W-5:0], which_digit(ln)};
                ec = ec + 4'd1;
                ep = 1;
            end
        end
        keys = ln[9:0]; key_start = ln[10]; key_cancel = ln[11]; db_ok = 1'b0;
        tick();
        db_ok = 1'b1; pc = 0; pat = 0;
        for (int i = 1; i <= hold; i++) begin
            tick();
            if (key_pulse) begin pc++; pat = i; end
            if (i == 2) check("upd_latency", digits, ed);
        end
        keys = '0; key_start = 1'b0; key_cancel = 1'b0; db_ok = 1'b0;
        repeat (3) begin tick(); if (key_pulse) pc++; end
        check("pulse_count", pc, ep);
        if (ep == 1) check("pulse_cycle", pat, 2);
        check("digits", digits, ed);
        check("digit_cnt", digit_cnt, ec);
        m_digits = ed; m_cnt = ec;
    endtask

    // Start press that is expected to produce an offer.
    task automatic start_offer(input int rdy, input bit cxl, input int cat);
        logic [W-1:0] et;
        int vc, lat;
        et = m_digits;
        key_start = 1'b1; db_ok = 1'b1; load_ready = 1'b0; lat = 0;
        while (!load_valid && lat < 10) begin
            tick(); lat++;
            if (lat == 2) check("start_pulse", key_pulse, 1);
        end
        check("start_latency", lat, 2);
        vc = 0;
        while (load_valid && vc < 20) begin
            vc++;
            check("tout_stable", time_out, et);
            check("digits_frozen", digits, et);
            if (cxl) begin
                if (vc == cat) key_cancel = 1'b1;
            end else load_ready = (vc > rdy);
            tick();
        end
        check("valid_cycles", vc, cxl ? cat : rdy + 1);
        check("end_pulse", key_pulse, cxl ? 1 : 0);
        check("offer_digits", digits, 0);
        check("offer_cnt", digit_cnt, 0);
        load_ready = 1'b0; key_start = 1'b0; key_cancel = 1'b0; db_ok = 1'b0;
        repeat (3) tick();
        check("valid_after", load_valid, 0);
        m_digits = '0; m_cnt = '0;
    endtask

    initial begin
        clear = 1'b0; keys = 10'h3FF; key_start = 1'b1; key_cancel = 1'b0;
        db_ok = 1'b1; entry_en = 1'b1; load_ready = 1'b0;
        m_digits = '0; m_cnt = '0;
        repeat (3) tick();
        check("rst_digits", digits, 0);
        check("rst_cnt", digit_cnt, 0);
        check("rst_pulse", key_pulse, 0);
        check("rst_valid", load_valid, 0);
        check("rst_tout", time_out, 0);
        keys = '0; key_start = 1'b0; db_ok = 1'b0;
        tick();
        clear = 1'b1;
        repeat (3) tick();
        check("idle_digits", digits, 0);
        check("idle_valid", load_valid, 0);

        // Full entry, then a press on a full register
        press(dkey(1), 5); press(dkey(2), 5); press(dkey(3), 5); press(dkey(0), 5);
        check("entry_1230", digits, 16'h1230);
        check("entry_cnt4", digit_cnt, 4);
        press(dkey(7), 5);
        check("full_ignored", digits, 16'h1230);

        // Start handshake with a slow timer
        press(dkey(11), 5);
        press(dkey(1), 5); press(dkey(3), 5); press(dkey(0), 5);
        check("pre_start", digits, 16'h0130);
        start_offer(3, 1'b0, 0);

        // Long hold gives one shift; chord is ignored
        press(dkey(5), 50);
        check("hold_once", digits, 16'h0005);
        press(dkey(2) | dkey(3), 6);
        check("chord_ignored", digits, 16'h0005);

        // Cancel during offer
        press(dkey(4), 5);
        start_offer(0, 1'b1, 2);

        // Entry disabled: digits/start ignored, cancel honoured
        press(dkey(6), 5);
        entry_en = 1'b0;
        press(dkey(8), 5);
        press(dkey(10), 5);
        check("dis_no_offer", load_valid, 0);
        press(dkey(11), 5);
        check("dis_cancel", digits, 0);
        entry_en = 1'b1;

        // Asynchronous clear in the middle of an offer
        press(dkey(9), 5);
        key_start = 1'b1; db_ok = 1'b1;
        tick(); tick();
        check("ar_offer", load_valid, 1);
        @(posedge clk);
        #3 clear = 1'b0;
        #1;
        check("ar_valid_drop", load_valid, 0);
        check("ar_digits", digits, 0);
        key_start = 1'b0; db_ok = 1'b0;
        tick();
        clear = 1'b1;
        tick();
        m_digits = '0; m_cnt = '0;

        // Random presses against the model
        for (int it = 0; it < 40; it++) begin
            int r, a, b;
            r = $urandom_range(0, 9);
            a = $urandom_range(0, 9);
            b = (a + 1 + $urandom_range(0, 9)) % 11;
            case (r)
                6: press(dkey(a) | dkey(b), 2 + $urandom_range(0, 4));
                7: press(dkey(11), 2 + $urandom_range(0, 4));
                8: begin
                    if (entry_en && m_cnt != 0)
                        start_offer($urandom_range(0, 3), ($urandom_range(0, 3) == 0), 1 + $urandom_range(0, 2));
                    else
                        press(dkey(10), 3);
                end
                9: begin
                    entry_en = ($urandom_range(0, 4) != 0);
                    press(dkey(a), 3);
                end
                default: press(dkey(a), 2 + $urandom_range(0, 6));
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
